inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
- Instruction encoder for the DL475 ARM-subset core: the inverse of the instruction-class decoder.
- Accepts a decoded instruction description (class, sub-type, registers, immediate) over a valid/ready handshake and assembles the 32-bit machine word.
- Buffers encoded words in a small FIFO and hands them out with a running byte address, so the stream can be written into instruction memory by a loader/testbench.

Parameters:
- DEPTH, 4, output FIFO entries (power of two, >=2)
- ADDR_W, 16, width of the output byte-address counter

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept a request this cycle
- instype  in  2  class: 00 data, 01 memory, 10 branch, 11 illegal
- datainstype  in  3  data op: 0 AND, 1 EOR, 2 SUB, 3 ADD, 4 ORR, 5 MOV, 6 CMP, 7 illegal
- meminstype  in  2  00 STR, 01 LDR, 10 STRB, 11 LDRB
- branchinstype  in  2  00 B, 01 BL, 10 BEQ, 11 BNE
- imm_sel  in  1  1 = immediate operand / offset
- set_flags  in  1  S bit (data class only)
- rn  in  4  base/first source register
- rd  in  4  destination/data register
- imm  in  24  src2/offset in [11:0]; branch offset in [23:0]
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer takes head
- out_inst  out  32  encoded word at FIFO head
- out_addr  out  ADDR_W  byte address of head word
- addr_clr  in  1  synchronous clear of address counter
- enc_err  out  1  one-cycle pulse: illegal request dropped

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: FIFO empty, out_valid=0, out_inst=0, out_addr=0, enc_err=0, in_ready=1.
- Accept: a request is accepted when in_valid && in_ready.
  - in_ready = (count < DEPTH). It depends only on registered occupancy, so there is no combinational path from out_ready.
- Latency: an accepted word is written to the FIFO at that edge; out_valid can rise the next cycle.
- Encoding, common bits: cond[31:28]=1110, except BEQ=0000 and BNE=0001.
- Data class:
  - [27:26]=00, [25]=imm_sel, [24:21]=cmd, [20]=set_flags, [19:16]=rn, [15:12]=rd, [11:0]=imm[11:0].
  - cmd values: AND 0000, EOR 0001, SUB 0010, ADD 0100, ORR 1100, MOV 1101, CMP 1010.
  - CMP forces S=1 and rd=0. MOV forces rn=0.
- Memory class:
  - [27:26]=01, [25]=~imm_sel, P[24]=1, U[23]=1, B[22]=meminstype[1], W[21]=0, L[20]=~meminstype[0]^1 (LDR/LDRB -> 1).
  - [19:16]=rn, [15:12]=rd, [11:0]=imm[11:0].
- Branch class: [27:25]=101, [24]=1 only for BL, [23:0]=imm.
- Illegal request (instype=11, or data class with datainstype=7):
  - Accepted (handshake completes) but not enqueued.
  - enc_err pulses high for exactly the cycle after acceptance.
- Pop: on out_valid && out_ready, the head advances and out_addr += 4.
  - out_addr wraps modulo 2^ADDR_W.
- addr_clr: sets out_addr=0 at the next edge and has priority over the pop increment. FIFO contents are unaffected.
- Simultaneous push and pop:
  - Allowed whenever in_ready=1. Count unchanged.
  - When full, in_ready=0, so no push occurs even if a pop occurs that cycle.
- Empty: out_valid=0; out_inst holds its last value (don't-care for the bench).
- Reset mid-operation: all queued words are discarded; state returns to the reset values above.

Optional Feature:
- Macro: INST_ENC_STATS_EN.
- When defined:
  - Extra outputs stat_data, stat_mem, stat_branch, stat_err, each 16 bits.
  - Each counts accepted requests of its category, saturating at 16'hFFFF.
  - All four reset to 0 on rst_n and clear on addr_clr.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package inst_pkg holds:
  - instype/datainstype/meminstype/branchinstype enum constants
  - ARM cmd codes
  - cond codes (AL, EQ, NE)
  - field bit positions

  The existing decoder uses the same package.
- Sub-module inst_fifo: a parameterised synchronous FIFO (DEPTH x 32), with full/empty and count.
- The encoding logic is combinational in inst_encoder, feeding inst_fifo's write port.

Test Plan:
- ADD R1,R2,#5 (instype 00, datainstype 3, imm_sel 1, S 0, rn 2, rd 1, imm 5) -> out_inst 32'hE2821005, out_addr 0.
- LDR R3,[R4,#8] (instype 01, meminstype 01, imm_sel 1, rn 4, rd 3, imm 8) -> 32'hE5943008, out_addr 4. BL imm 24'h000010 -> 32'hEB000010; BEQ imm 24'hFFFFFE -> 32'h0AFFFFFE.
- Illegal (instype 00, datainstype 7) -> accepted, enc_err one-cycle pulse, no FIFO entry, out_addr unchanged.
- Backpressure: out_ready=0, push 5 valid requests -> in_ready low after 4 accepts. Raise out_ready -> words drain in order at addresses 0,4,8,12,16, with the fifth accepted once space frees.
- Simultaneous push/pop at count 2 for 10 cycles -> count stays 2, order preserved. Assert rst_n=0 mid-stream -> out_valid=0, out_addr=0 immediately.
- ADDR_W=4: 5 pops -> out_addr sequence 0,4,8,12,0. addr_clr asserted with a pop -> out_addr=0.

Source files
------------

// File: rtl/inst_pkg.sv
// Shared instruction-set constants for the DL475 ARM-subset encoder and decoder.
// Holds class/sub-type enums, ARM data-processing opcodes, condition codes
// and the bit positions of every field in the 32-bit machine word.
package inst_pkg;

  typedef enum logic [1:0] {
    CLS_DATA    = 2'b00,
    CLS_MEM     = 2'b01,
    CLS_BRANCH  = 2'b10,
    CLS_ILLEGAL = 2'b11
  } instype_e;

  typedef enum logic [2:0] {
    DOP_AND     = 3'd0,
    DOP_EOR     = 3'd1,
    DOP_SUB     = 3'd2,
    DOP_ADD     = 3'd3,
    DOP_ORR     = 3'd4,
    DOP_MOV     = 3'd5,
    DOP_CMP     = 3'd6,
    DOP_ILLEGAL = 3'd7
  } datainstype_e;

  typedef enum logic [1:0] {
    MEM_STR  = 2'b00,
    MEM_LDR  = 2'b01,
    MEM_STRB = 2'b10,
    MEM_LDRB = 2'b11
  } meminstype_e;

  typedef enum logic [1:0] {
    BR_B   = 2'b00,
    BR_BL  = 2'b01,
    BR_BEQ = 2'b10,
    BR_BNE = 2'b11
  } branchinstype_e;

  // ARM data-processing opcode field values
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  // Condition codes
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;

  // Field bit positions (LSB of multi-bit fields)
  localparam int COND_LSB  = 28;
  localparam int OP_LSB    = 26;
  localparam int I_BIT     = 25;
  localparam int CMD_LSB   = 21;
  localparam int S_BIT     = 20;
  localparam int RN_LSB    = 16;
  localparam int RD_LSB    = 12;
  localparam int P_BIT     = 24;
  localparam int U_BIT     = 23;
  localparam int B_BIT     = 22;
  localparam int W_BIT     = 21;
  localparam int L_BIT     = 20;
  localparam int LINK_BIT  = 24;
  localparam int BROP_LSB  = 25;

  // Map a data sub-type onto its ARM opcode; the illegal code maps to AND
  // but is never enqueued.
  function automatic logic [3:0] data_cmd(datainstype_e op);
    case (op)
      DOP_AND: data_cmd = CMD_AND;
      DOP_EOR: data_cmd = CMD_EOR;
      DOP_SUB: data_cmd = CMD_SUB;
      DOP_ADD: data_cmd = CMD_ADD;
      DOP_ORR: data_cmd = CMD_ORR;
      DOP_MOV: data_cmd = CMD_MOV;
      DOP_CMP: data_cmd = CMD_CMP;
      default: data_cmd = CMD_AND;
    endcase
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// Synchronous DEPTH x WIDTH FIFO with registered occupancy.
// DEPTH must be a power of two so the pointers wrap naturally.
// Pushes while full and pops while empty are ignored.
module inst_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage; cleared on reset so the head reads as zero out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Read/write pointers and occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// DL475 instruction encoder: turns a decoded instruction description into a
// 32-bit ARM-subset word, queues it, and presents it with a byte address.
// Optional per-category request counters are built when INST_ENC_STATS_EN
// is defined.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready, and in_ready depends only on
// registered FIFO occupancy (no combinational path from out_ready).
module inst_encoder
  import inst_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        instype,
  input  logic [2:0]        datainstype,
  input  logic [1:0]        meminstype,
  input  logic [1:0]        branchinstype,
  input  logic              imm_sel,
  input  logic              set_flags,
  input  logic [3:0]        rn,
  input  logic [3:0]        rd,
  input  logic [23:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  input  logic              addr_clr,
  output logic              enc_err
`ifdef INST_ENC_STATS_EN
  ,
  output logic [15:0]       stat_data,
  output logic [15:0]       stat_mem,
  output logic [15:0]       stat_branch,
  output logic [15:0]       stat_err
`endif
);

  instype_e       cls;
  datainstype_e   dop;
  meminstype_e    mop;
  branchinstype_e bop;

  logic [31:0]            enc_word;
  logic                   enc_legal;
  logic                   accept;
  logic                   push;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   unused_count;

  assign cls = instype_e'(instype);
  assign dop = datainstype_e'(datainstype);
  assign mop = meminstype_e'(meminstype);
  assign bop = branchinstype_e'(branchinstype);

  // Occupancy is observed through full/empty; count is kept for debug taps.
  assign unused_count = ^fifo_count;

  assign in_ready  = !fifo_full;
  assign accept    = in_valid && in_ready;
  assign push      = accept && enc_legal;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  // Combinational field assembly for the request currently on the inputs
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (cls)
      CLS_DATA: begin
        enc_legal                 = (dop != DOP_ILLEGAL);
        enc_word[COND_LSB +: 4]   = COND_AL;
        enc_word[OP_LSB +: 2]     = 2'b00;
        enc_word[I_BIT]           = imm_sel;
        enc_word[CMD_LSB +: 4]    = data_cmd(dop);
        enc_word[S_BIT]           = set_flags;
        enc_word[RN_LSB +: 4]     = rn;
        enc_word[RD_LSB +: 4]     = rd;
        enc_word[11:0]            = imm[11:0];
        // CMP always sets flags and has no destination
        if (dop == DOP_CMP) begin
          enc_word[S_BIT]         = 1'b1;
          enc_word[RD_LSB +: 4]   = 4'd0;
        end
        // MOV has no first operand
        if (dop == DOP_MOV) begin
          enc_word[RN_LSB +: 4]   = 4'd0;
        end
      end
      CLS_MEM: begin
        enc_word[COND_LSB +: 4]   = COND_AL;
        enc_word[OP_LSB +: 2]     = 2'b01;
        // ARM load/store I bit is inverted: 0 means immediate offset
        enc_word[I_BIT]           = !imm_sel;
        enc_word[P_BIT]           = 1'b1;
        enc_word[U_BIT]           = 1'b1;
        enc_word[B_BIT]           = mop[1];
        enc_word[W_BIT]           = 1'b0;
        // LDR/LDRB have meminstype[0]=1, which is exactly the load bit
        enc_word[L_BIT]           = mop[0];
        enc_word[RN_LSB +: 4]     = rn;
        enc_word[RD_LSB +: 4]     = rd;
        enc_word[11:0]            = imm[11:0];
      end
      CLS_BRANCH: begin
        case (bop)
          BR_BEQ:  enc_word[COND_LSB +: 4] = COND_EQ;
          BR_BNE:  enc_word[COND_LSB +: 4] = COND_NE;
          default: enc_word[COND_LSB +: 4] = COND_AL;
        endcase
        enc_word[BROP_LSB +: 3]   = 3'b101;
        enc_word[LINK_BIT]        = (bop == BR_BL);
        enc_word[23:0]            = imm;
      end
      default: begin
        enc_legal = 1'b0;
      end
    endcase
  end

  inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (enc_word),
    .pop     (pop),
    .rd_data (out_inst),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Byte address of the head word; clear wins over the pop increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_addr <= '0;
    end else if (addr_clr) begin
      out_addr <= '0;
    end else if (pop) begin
      out_addr <= out_addr + ADDR_W'(4);
    end
  end

  // One-cycle error pulse for an accepted but unencodable request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_err <= 1'b0;
    end else begin
      enc_err <= accept && !enc_legal;
    end
  end

`ifdef INST_ENC_STATS_EN
  // Saturating per-category counters of accepted requests
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_data   <= '0;
      stat_mem    <= '0;
      stat_branch <= '0;
      stat_err    <= '0;
    end else if (addr_clr) begin
      stat_data   <= '0;
      stat_mem    <= '0;
      stat_branch <= '0;
      stat_err    <= '0;
    end else if (accept) begin
      if (!enc_legal) begin
        if (stat_err != 16'hFFFF) stat_err <= stat_err + 16'd1;
      end else if (cls == CLS_DATA) begin
        if (stat_data != 16'hFFFF) stat_data <= stat_data + 16'd1;
      end else if (cls == CLS_MEM) begin
        if (stat_mem != 16'hFFFF) stat_mem <= stat_mem + 16'd1;
      end else begin
        if (stat_branch != 16'hFFFF) stat_branch <= stat_branch + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: table of known encodings, hand-written multi-cycle
// sequences (backpressure, push/pop at constant occupancy, reset mid-stream,
// address wrap with a narrow counter) and a randomized phase, all checked
// against a word/address scoreboard kept in the bench.
`timescale 1ns/1ps
module tb_inst_encoder;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 16;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [1:0]        instype = '0;
  logic [2:0]        datainstype = '0;
  logic [1:0]        meminstype = '0;
  logic [1:0]        branchinstype = '0;
  logic              imm_sel = 1'b0;
  logic              set_flags = 1'b0;
  logic [3:0]        rn = '0;
  logic [3:0]        rd = '0;
  logic [23:0]       imm = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_addr;
  logic              addr_clr = 1'b0;
  logic              enc_err;

  // narrow-address instance
  logic              in_valid4 = 1'b0;
  logic              in_ready4;
  logic              out_valid4;
  logic              out_ready4 = 1'b0;
  logic [31:0]       out_inst4;
  logic [3:0]        out_addr4;
  logic              addr_clr4 = 1'b0;
  logic              enc_err4;

`ifdef INST_ENC_STATS_EN
  logic [15:0] stat_data, stat_mem, stat_branch, stat_err;
  logic [15:0] stat_data4, stat_mem4, stat_branch4, stat_err4;
`endif

  inst_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dut (
    .clk (clk), .rst_n (rst_n),
    .in_valid (in_valid), .in_ready (in_ready),
    .instype (instype), .datainstype (datainstype), .meminstype (meminstype),
    .branchinstype (branchinstype), .imm_sel (imm_sel), .set_flags (set_flags),
    .rn (rn), .rd (rd), .imm (imm),
    .out_valid (out_valid), .out_ready (out_ready), .out_inst (out_inst),
    .out_addr (out_addr), .addr_clr (addr_clr), .enc_err (enc_err)
`ifdef INST_ENC_STATS_EN
    , .stat_data (stat_data), .stat_mem (stat_mem),
    .stat_branch (stat_branch), .stat_err (stat_err)
`endif
  );

  inst_encoder #(.DEPTH(DEPTH), .ADDR_W(4)) u_dut4 (
    .clk (clk), .rst_n (rst_n),
    .in_valid (in_valid4), .in_ready (in_ready4),
    .instype (instype), .datainstype (datainstype), .meminstype (meminstype),
    .branchinstype (branchinstype), .imm_sel (imm_sel), .set_flags (set_flags),
    .rn (rn), .rd (rd), .imm (imm),
    .out_valid (out_valid4), .out_ready (out_ready4), .out_inst (out_inst4),
    .out_addr (out_addr4), .addr_clr (addr_clr4), .enc_err (enc_err4)
`ifdef INST_ENC_STATS_EN
    , .stat_data (stat_data4), .stat_mem (stat_mem4),
    .stat_branch (stat_branch4), .stat_err (stat_err4)
`endif
  );

  // ---------------- comparison bookkeeping ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // ---------------- request records and reference model ----------------
  typedef struct {
    logic [1:0]  cls;
    logic [2:0]  dop;
    logic [1:0]  mop;
    logic [1:0]  bop;
    logic        isel;
    logic        s;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [23:0] imm;
    logic        illegal;
    logic [31:0] word;
  } vec_t;

  // ARM opcode by data sub-type (AND EOR SUB ADD ORR MOV CMP, pad)
  int cmd_of [8] = '{0, 1, 2, 4, 12, 13, 10, 0};

  function automatic bit model_illegal(vec_t v);
    return (v.cls == 2'd3) || (v.cls == 2'd0 && v.dop == 3'd7);
  endfunction

  function automatic logic [31:0] model_word(vec_t v);
    logic [31:0] w;
    int s, r_n, r_d, cond;
    w = '0;
    case (v.cls)
      2'd0: begin
        s   = v.s;
        r_n = v.rn;
        r_d = v.rd;
        if (v.dop == 3'd6) begin s = 1; r_d = 0; end
        if (v.dop == 3'd5) r_n = 0;
        w = (32'd14 << 28) | (32'(v.isel) << 25) | (32'(cmd_of[v.dop]) << 21) |
            (32'(s) << 20) | (32'(r_n) << 16) | (32'(r_d) << 12) | (32'(v.imm) & 32'hFFF);
      end
      2'd1: begin
        w = (32'd14 << 28) | (32'd1 << 26) | (32'(!v.isel) << 25) | (32'd3 << 23) |
            (32'(v.mop[1]) << 22) | (32'(v.mop[0]) << 20) |
            (32'(v.rn) << 16) | (32'(v.rd) << 12) | (32'(v.imm) & 32'hFFF);
      end
      2'd2: begin
        cond = (v.bop == 2'd2) ? 0 : (v.bop == 2'd3) ? 1 : 14;
        w = (32'(cond) << 28) | (32'd5 << 25) | (32'(v.bop == 2'd1) << 24) | 32'(v.imm);
      end
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic vec_t mk(input logic [1:0] cls, input logic [2:0] dop,
                              input logic [1:0] mop, input logic [1:0] bop,
                              input logic isel, input logic s, input logic [3:0] rn_v,
                              input logic [3:0] rd_v, input logic [23:0] imm_v,
                              input logic ill, input logic [31:0] word);
    vec_t v;
    v.cls = cls; v.dop = dop; v.mop = mop; v.bop = bop; v.isel = isel; v.s = s;
    v.rn = rn_v; v.rd = rd_v; v.imm = imm_v; v.illegal = ill; v.word = word;
    return v;
  endfunction

  function automatic vec_t rand_vec(input bit allow_illegal);
    vec_t v;
    v.cls  = 2'($urandom_range(0, allow_illegal ? 3 : 2));
    v.dop  = 3'($urandom_range(0, allow_illegal ? 7 : 6));
    v.mop  = 2'($urandom_range(0, 3));
    v.bop  = 2'($urandom_range(0, 3));
    v.isel = 1'($urandom_range(0, 1));
    v.s    = 1'($urandom_range(0, 1));
    v.rn   = 4'($urandom_range(0, 15));
    v.rd   = 4'($urandom_range(0, 15));
    v.imm  = 24'($urandom());
    v.illegal = model_illegal(v);
    v.word    = model_word(v);
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  logic [31:0]       exp_q[$];
  logic [ADDR_W-1:0] exp_addr = '0;
  bit                err_pending = 0;
  int                pops_seen = 0;
  logic [31:0]       cur_word = '0;
  bit                cur_illegal = 0;

  // Checked away from the active edge; events seen here commit at the next rising edge
  always @(negedge clk) begin
    bit model_pop;
    if (!rst_n) begin
      exp_q.delete();
      exp_addr    = '0;
      err_pending = 0;
    end else begin
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
      chk("enc_err", 32'(enc_err), 32'(err_pending));
      err_pending = 0;
      model_pop = (exp_q.size() != 0) && out_ready;
      if (model_pop) begin
        chk("out_inst", out_inst, exp_q.pop_front());
        chk("out_addr", 32'(out_addr), 32'(exp_addr));
        pops_seen++;
      end
      if (addr_clr) exp_addr = '0;
      else if (model_pop) exp_addr = exp_addr + ADDR_W'(4);
      if (in_valid && in_ready) begin
        if (cur_illegal) err_pending = 1;
        else exp_q.push_back(cur_word);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic apply_vec(input vec_t v);
    instype = v.cls; datainstype = v.dop; meminstype = v.mop; branchinstype = v.bop;
    imm_sel = v.isel; set_flags = v.s; rn = v.rn; rd = v.rd; imm = v.imm;
    cur_word = v.word; cur_illegal = v.illegal;
    in_valid = 1'b1;
  endtask

  // Present a request and hold it until it is accepted (bounded)
  task automatic send(input vec_t v);
    int waited;
    waited = 0;
    apply_vec(v);
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 50) begin
        timeout("send");
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 60) begin
      @(posedge clk); c++;
    end
    if (exp_q.size() != 0) timeout(name);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  vec_t tab[17];
  logic [3:0] a4[$];
  logic [3:0] a4_exp [5] = '{4'd0, 4'd4, 4'd8, 4'd12, 4'd0};

  initial begin
    vec_t v;
    int acc, npop;

    tab[0]  = mk(2'd0, 3'd3, 2'd0, 2'd0, 1, 0, 4'd2,  4'd1,  24'h000005, 0, 32'hE2821005);
    tab[1]  = mk(2'd1, 3'd0, 2'd1, 2'd0, 1, 0, 4'd4,  4'd3,  24'h000008, 0, 32'hE5943008);
    tab[2]  = mk(2'd2, 3'd0, 2'd0, 2'd1, 0, 0, 4'd0,  4'd0,  24'h000010, 0, 32'hEB000010);
    tab[3]  = mk(2'd2, 3'd0, 2'd0, 2'd2, 0, 0, 4'd0,  4'd0,  24'hFFFFFE, 0, 32'h0AFFFFFE);
    tab[4]  = mk(2'd0, 3'd7, 2'd0, 2'd0, 1, 0, 4'd1,  4'd1,  24'h000001, 1, 32'h0);
    tab[5]  = mk(2'd0, 3'd6, 2'd0, 2'd0, 0, 0, 4'd5,  4'd9,  24'h000003, 0, 32'hE1550003);
    tab[6]  = mk(2'd0, 3'd5, 2'd0, 2'd0, 1, 1, 4'd3,  4'd7,  24'h0000FF, 0, 32'hE3B070FF);
    tab[7]  = mk(2'd1, 3'd0, 2'd2, 2'd0, 1, 0, 4'd1,  4'd2,  24'h000004, 0, 32'hE5C12004);
    tab[8]  = mk(2'd2, 3'd0, 2'd0, 2'd3, 0, 0, 4'd0,  4'd0,  24'h000003, 0, 32'h1A000003);
    tab[9]  = mk(2'd3, 3'd0, 2'd0, 2'd0, 0, 0, 4'd0,  4'd0,  24'h000000, 1, 32'h0);
    tab[10] = mk(2'd0, 3'd2, 2'd0, 2'd0, 0, 1, 4'd0,  4'd0,  24'h000001, 0, 32'hE0500001);
    tab[11] = mk(2'd1, 3'd0, 2'd3, 2'd0, 0, 0, 4'd6,  4'd8,  24'hFFFFFF, 0, 32'hE7D68FFF);
    tab[12] = mk(2'd2, 3'd0, 2'd0, 2'd0, 0, 0, 4'd0,  4'd0,  24'h800000, 0, 32'hEA800000);
    tab[13] = mk(2'd0, 3'd1, 2'd0, 2'd0, 1, 0, 4'd1,  4'd2,  24'h123ABC, 0, 32'hE2212ABC);
    tab[14] = mk(2'd0, 3'd4, 2'd0, 2'd0, 0, 0, 4'd3,  4'd4,  24'h000005, 0, 32'hE1834005);
    tab[15] = mk(2'd0, 3'd0, 2'd0, 2'd0, 1, 1, 4'd15, 4'd14, 24'h000001, 0, 32'hE21FE001);
    tab[16] = mk(2'd1, 3'd0, 2'd0, 2'd0, 1, 0, 4'd13, 4'd14, 24'h000010, 0, 32'hE58DE010);

    // reset state
    repeat (2) @(posedge clk); #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_out_addr", 32'(out_addr), 32'd0);
    chk("rst_enc_err", 32'(enc_err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 4-bit address counter: five pops wrap 0,4,8,12,0
    apply_vec(tab[0]);
    in_valid = 1'b0;
    in_valid4 = 1'b1;
    out_ready4 = 1'b1;
    acc = 0; npop = 0;
    for (int c = 0; c < 40 && npop < 5; c++) begin
      @(negedge clk);
      if (in_valid4 && in_ready4) acc++;
      if (out_valid4 && out_ready4) begin
        a4.push_back(out_addr4);
        chk("w4_word", out_inst4, 32'hE2821005);
        npop++;
      end
      chk("w4_enc_err", 32'(enc_err4), 32'd0);
      @(posedge clk); #1;
      if (acc >= 5) in_valid4 = 1'b0;
    end
    in_valid4 = 1'b0;
    chk("w4_pops", 32'(a4.size()), 32'd5);
    for (int i = 0; i < 5 && i < a4.size(); i++) chk("w4_addr_seq", 32'(a4[i]), 32'(a4_exp[i]));
    chk("w4_addr_after", 32'(out_addr4), 32'd4);
    // addr_clr together with a pop: clear wins
    out_ready4 = 1'b0;
    in_valid4 = 1'b1;
    @(negedge clk);
    chk("w4_ready", 32'(in_ready4), 32'd1);
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    @(negedge clk);
    chk("w4_valid", 32'(out_valid4), 32'd1);
    @(posedge clk); #1;
    out_ready4 = 1'b1; addr_clr4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0; addr_clr4 = 1'b0;
    chk("w4_clr_pop_addr", 32'(out_addr4), 32'd0);
    chk("w4_clr_pop_valid", 32'(out_valid4), 32'd0);

    // table of known encodings, consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) send(tab[i]);
    wait_drain("table_drain");

    // backpressure: four fill the FIFO, the fifth waits for space
    addr_clr = 1'b1;
    @(posedge clk); #1;
    addr_clr = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(rand_vec(0));
    @(negedge clk);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    fork
      send(rand_vec(0));
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain("bp_drain");
    chk("addr_after_drain", 32'(out_addr), 32'd20);

    // simultaneous push and pop at occupancy 2
    out_ready = 1'b0;
    send(rand_vec(0));
    send(rand_vec(0));
    for (int c = 0; c < 10; c++) begin
      apply_vec(rand_vec(0));
      out_ready = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    pops_seen = 0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk); #1;
    out_ready = 1'b0;
    chk("occupancy_after_pushpop", 32'(pops_seen), 32'd2);

    // reset mid-stream
    for (int i = 0; i < 3; i++) send(rand_vec(0));
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_addr", 32'(out_addr), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_inst", out_inst, 32'd0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // randomized traffic including illegal requests and address clears
    for (int c = 0; c < 400; c++) begin
      v = rand_vec(1);
      apply_vec(v);
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      addr_clr  = ($urandom_range(0, 15) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    addr_clr = 1'b0;
    out_ready = 1'b1;
    wait_drain("rand_drain");
    chk("final_empty", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // absolute time limit
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
